// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioning block: FSM encodings,
// clock frequency and default timing constants (100 MHz operation).
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_e;

  localparam int unsigned CLK_FREQ_HZ         = 100_000_000;
  localparam int unsigned DEF_NUM_BTN         = 4;
  localparam int unsigned DEF_SYNC_STAGES     = 2;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = CLK_FREQ_HZ / 100;  // 10 ms
  localparam int unsigned DEF_REPEAT_DELAY    = CLK_FREQ_HZ / 2;    // 0.5 s
  localparam int unsigned DEF_REPEAT_PERIOD   = CLK_FREQ_HZ / 10;   // 0.1 s

endpackage

// File: rtl/button_debounce_repeat_if.sv
// Button bundle: raw levels in, conditioned levels and event pulses out.
interface button_debounce_repeat_if #(
  parameter int unsigned NUM_BTN = btn_pkg::DEF_NUM_BTN
);

  logic [NUM_BTN-1:0] btn_in;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_press;
  logic [NUM_BTN-1:0] btn_release;
  logic [NUM_BTN-1:0] btn_repeat;

  // Board side: drives raw buttons, consumes conditioned outputs.
  modport master (
    output btn_in,
    input  btn_level,
    input  btn_press,
    input  btn_release,
    input  btn_repeat
  );

  // Conditioning block side.
  modport slave (
    input  btn_in,
    output btn_level,
    output btn_press,
    output btn_release,
    output btn_repeat
  );

endinterface

// File: rtl/button_channel.sv
// One button: input synchroniser, debounce FSM, press/release pulses and
// auto-repeat pulses while the button stays held.
module button_channel
  import btn_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk_100M,
  input  logic reset,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_repeat
);

  localparam int unsigned DCNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned RCNT_W = $clog2(REPEAT_DELAY + REPEAT_PERIOD);

  localparam logic [DCNT_W-1:0] DCNT_ONE    = DCNT_W'(1);
  localparam logic [DCNT_W-1:0] DCNT_LAST   = DCNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RCNT_W-1:0] RCNT_ONE    = RCNT_W'(1);
  localparam logic [RCNT_W-1:0] RCNT_FIRST  = RCNT_W'(REPEAT_DELAY - 1);
  localparam logic [RCNT_W-1:0] RCNT_NEXT   = RCNT_W'(REPEAT_DELAY + REPEAT_PERIOD - 1);
  localparam logic [RCNT_W-1:0] RCNT_RELOAD = RCNT_W'(REPEAT_DELAY);
  localparam logic [RCNT_W-1:0] RCNT_MAX    = '1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  btn_state_e        state_q, state_d;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;
  logic [RCNT_W-1:0] rcnt_q, rcnt_d;
  logic              level_d, press_d, release_d, repeat_d;

  assign s = sync_q[SYNC_STAGES-1];

  // Shift the raw asynchronous level through the synchroniser chain.
  always_ff @(posedge clk_100M or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in};
  end

  // FSM state, counters and registered outputs.
  always_ff @(posedge clk_100M or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      dcnt_q      <= '0;
      rcnt_q      <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      btn_repeat  <= 1'b0;
    end else begin
      state_q     <= state_d;
      dcnt_q      <= dcnt_d;
      rcnt_q      <= rcnt_d;
      btn_level   <= level_d;
      btn_press   <= press_d;
      btn_release <= release_d;
      btn_repeat  <= repeat_d;
    end
  end

  // Next state, counter updates and pulse generation.
  always_comb begin
    state_d   = state_q;
    dcnt_d    = dcnt_q;
    rcnt_d    = rcnt_q;
    level_d   = btn_level;
    press_d   = 1'b0;
    release_d = 1'b0;
    repeat_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (s) begin
          state_d = PRESS_WAIT;
          dcnt_d  = DCNT_ONE;
        end
      end

      PRESS_WAIT: begin
        if (!s) begin
          state_d = IDLE;
        end else if (dcnt_q == DCNT_LAST) begin
          state_d = HELD;
          level_d = 1'b1;
          press_d = 1'b1;
          rcnt_d  = '0;
        end else begin
          dcnt_d = dcnt_q + DCNT_ONE;
        end
      end

      HELD: begin
        // After the first repeat the counter is reloaded so later repeats
        // fall every REPEAT_PERIOD cycles; it can never pass RCNT_NEXT.
        if (rcnt_q == RCNT_FIRST) begin
          repeat_d = 1'b1;
          rcnt_d   = rcnt_q + RCNT_ONE;
        end else if (rcnt_q == RCNT_NEXT) begin
          repeat_d = 1'b1;
          rcnt_d   = RCNT_RELOAD;
        end else if (rcnt_q != RCNT_MAX) begin
          rcnt_d = rcnt_q + RCNT_ONE;
        end
        if (!s) begin
          state_d = RELEASE_WAIT;
          dcnt_d  = DCNT_ONE;
        end
      end

      RELEASE_WAIT: begin
        if (s) begin
          state_d = HELD;
        end else if (dcnt_q == DCNT_LAST) begin
          state_d   = IDLE;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          dcnt_d = dcnt_q + DCNT_ONE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/button_debounce_repeat.sv
// Conditions all raw push-buttons: one independent button_channel per input.
module button_debounce_repeat
  import btn_pkg::*;
#(
  parameter int unsigned NUM_BTN         = DEF_NUM_BTN,
  parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic                     clk_100M,
  input  logic                     reset,
  button_debounce_repeat_if.slave  bus
);

  logic [NUM_BTN-1:0] level_w;
  logic [NUM_BTN-1:0] press_w;
  logic [NUM_BTN-1:0] release_w;
  logic [NUM_BTN-1:0] repeat_w;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    button_channel #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_ch (
      .clk_100M    (clk_100M),
      .reset       (reset),
      .btn_in      (bus.btn_in[i]),
      .btn_level   (level_w[i]),
      .btn_press   (press_w[i]),
      .btn_release (release_w[i]),
      .btn_repeat  (repeat_w[i])
    );
  end

  assign bus.btn_level   = level_w;
  assign bus.btn_press   = press_w;
  assign bus.btn_release = release_w;
  assign bus.btn_repeat  = repeat_w;

endmodule

// File: tb/tb_button_debounce_repeat.sv
// Scoreboard bench for button_debounce_repeat with short timing constants.
module tb_button_debounce_repeat;

  localparam int unsigned NB  = 4;
  localparam int unsigned SS  = 2;
  localparam int unsigned DC  = 4;
  localparam int unsigned RD  = 20;
  localparam int unsigned RP  = 8;
  localparam int          LAT = SS + DC;

  typedef enum int {EV_PRESS, EV_RELEASE, EV_REPEAT} ev_kind_e;
  typedef struct {
    int       cyc;
    int       ch;
    ev_kind_e kind;
  } ev_t;

  logic clk_100M = 1'b0;
  logic reset;

  button_debounce_repeat_if #(.NUM_BTN(NB)) bus ();

  button_debounce_repeat #(
    .NUM_BTN         (NB),
    .SYNC_STAGES     (SS),
    .DEBOUNCE_CYCLES (DC),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk_100M (clk_100M),
    .reset    (reset),
    .bus      (bus)
  );

  always #5 clk_100M = ~clk_100M;

  int          checks    = 0;
  int          failures  = 0;
  int          cyc       = 0;
  ev_t         sb[$];
  logic [NB-1:0] exp_level = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic push(input int c, input int ch, input ev_kind_e k);
    ev_t e;
    e.cyc  = c;
    e.ch   = ch;
    e.kind = k;
    sb.push_back(e);
  endtask

  // Repeats while held: press+RD, then every RP, up to and including last_edge.
  task automatic push_repeats(input int ch, input int p, input int last_edge);
    int t;
    t = p + RD;
    while (t <= last_edge) begin
      push(t, ch, EV_REPEAT);
      t += RP;
    end
  endtask

  // Advance one clock, pop this cycle's expected events and compare outputs.
  task automatic tick();
    logic [NB-1:0] ep, er, et;
    ep = '0;
    er = '0;
    et = '0;
    @(posedge clk_100M);
    #1;
    cyc++;
    for (int i = int'(sb.size()) - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        case (sb[i].kind)
          EV_PRESS:   begin ep[sb[i].ch] = 1'b1; exp_level[sb[i].ch] = 1'b1; end
          EV_RELEASE: begin er[sb[i].ch] = 1'b1; exp_level[sb[i].ch] = 1'b0; end
          default:    et[sb[i].ch] = 1'b1;
        endcase
        sb.delete(i);
      end
    end
    chk("press",   32'(bus.btn_press),   32'(ep));
    chk("release", 32'(bus.btn_release), 32'(er));
    chk("repeat",  32'(bus.btn_repeat),  32'(et));
    chk("level",   32'(bus.btn_level),   32'(exp_level));
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  initial begin
    int p, r, g, c, d;
    reset      = 1'b1;
    bus.btn_in = '1;

    // All buttons held through reset: outputs stay 0, then a joint press.
    run_to(10);
    reset = 1'b0;
    for (int ch = 0; ch < int'(NB); ch++) begin
      push(cyc + LAT, ch, EV_PRESS);
      push(20 + LAT, ch, EV_RELEASE);
    end
    run_to(20);
    bus.btn_in = '0;
    run_to(40);

    // Channel 1 held long enough for two repeats; released edge r seen at r+3.
    p = cyc + LAT;
    r = p + 30;
    push(p, 1, EV_PRESS);
    push_repeats(1, p, r + SS + 1);
    push(r + LAT, 1, EV_RELEASE);
    bus.btn_in[1] = 1'b1;
    run_to(r);
    bus.btn_in[1] = 1'b0;
    run_to(r + LAT + 5);

    // Channel 0 short pulses of 1..3 cycles are rejected; 4 cycles is accepted.
    for (int w = 1; w <= 3; w++) begin
      c = cyc;
      bus.btn_in[0] = 1'b1;
      run_to(c + w);
      bus.btn_in[0] = 1'b0;
      run_to(c + w + 10);
    end
    c = cyc;
    push(c + LAT, 0, EV_PRESS);
    push(c + 4 + LAT, 0, EV_RELEASE);
    bus.btn_in[0] = 1'b1;
    run_to(c + 4);
    bus.btn_in[0] = 1'b0;
    run_to(c + 20);

    // Channel 2: 2-cycle low glitch while held. The repeat counter pauses for
    // the two cycles spent bouncing, so later repeats slip by two cycles.
    p = cyc + LAT;
    g = p + 22;
    r = p + 40;
    push(p, 2, EV_PRESS);
    push(p + RD, 2, EV_REPEAT);
    push(p + RD + RP + 2, 2, EV_REPEAT);
    push(p + RD + 2 * RP + 2, 2, EV_REPEAT);
    push(r + LAT, 2, EV_RELEASE);
    bus.btn_in[2] = 1'b1;
    run_to(g);
    bus.btn_in[2] = 1'b0;
    run_to(g + 2);
    bus.btn_in[2] = 1'b1;
    run_to(r);
    bus.btn_in[2] = 1'b0;
    run_to(r + LAT + 5);

    // Channel 3: one repeat, then release; nothing further afterwards.
    p = cyc + LAT;
    r = p + 24;
    push(p, 3, EV_PRESS);
    push_repeats(3, p, r + SS + 1);
    push(r + LAT, 3, EV_RELEASE);
    bus.btn_in[3] = 1'b1;
    run_to(r);
    bus.btn_in[3] = 1'b0;
    run_to(r + LAT + 30);

    // Reset while channel 1 is HELD: outputs clear at once, fresh press after.
    p = cyc + LAT;
    push(p, 1, EV_PRESS);
    bus.btn_in[1] = 1'b1;
    run_to(p + 10);
    chk("pre_reset_level", 32'(bus.btn_level), 32'(4'b0010));
    reset = 1'b1;
    #1;
    chk("async_level",   32'(bus.btn_level),   32'(0));
    chk("async_press",   32'(bus.btn_press),   32'(0));
    chk("async_release", 32'(bus.btn_release), 32'(0));
    chk("async_repeat",  32'(bus.btn_repeat),  32'(0));
    sb.delete();
    exp_level = '0;
    run_to(cyc + 3);
    reset = 1'b0;
    d = cyc;
    r = d + 10;
    push(d + LAT, 1, EV_PRESS);
    push(r + LAT, 1, EV_RELEASE);
    run_to(r);
    bus.btn_in[1] = 1'b0;
    run_to(r + LAT + 5);

    chk("sb_empty", 32'(sb.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
